lsu_rmw: RTL and testbench
==========================

// Module: lsu_rmw
// PURPOSE
//  Load/store unit between the core execute stage and the word-only data memory (DMEM).
//  DMEM has one full-word store enable, so this block converts SB/SH stores into a two-cycle
//  read-modify-write (RMW). Word stores pass through in one cycle.
//  For LB/LH/LBU/LHU/LW it extracts the addressed lane, sign- or zero-extends it, and returns it one cycle later.
// PARAMETERS
//  DATA_W  32  data word width; fixed at 32
//  ADDR_W  10  DMEM word-address width; byte address is ADDR_W+2 bits
// PORTS
//  clk_i           in   1         sole clock, rising edge
//  rst_i           in   1         reset, asynchronous, active-high
//  req_valid_i     in   1         request present from execute stage
//  req_ready_o     out  1         block can accept; transfer when valid&&ready
//  req_we_i        in   1         1=store, 0=load
//  req_size_i      in   2         lsu_pkg::size_e: SZ_B=0, SZ_H=1, SZ_W=2 (3 is illegal and treated as SZ_W)
//  req_unsigned_i  in   1         loads: 1=zero-extend, 0=sign-extend
//  req_addr_i      in   ADDR_W+2  byte address
//  req_wdata_i     in   DATA_W    store data, right-justified
//  rsp_valid_o     out  1         load data valid (1-cycle pulse)
//  rsp_rdata_o     out  DATA_W    extended load data
//  err_o           out  1         misaligned-access pulse (MISALIGN_TRAP_EN only; else tied 0)
//  dmem_addr_o     out  ADDR_W    word address to DMEM
//  dmem_st_data_o  out  DATA_W    full word to store
//  dmem_st_en_o    out  1         DMEM store enable; DMEM writes on the clk_i edge
//  dmem_ld_data_i  in   DATA_W    DMEM combinational read data for dmem_addr_o
// BEHAVIOUR
//  Reset: state=IDLE; rsp_valid_o=0, rsp_rdata_o=0, err_o=0, dmem_st_en_o=0; merge register=0.
//  States (lsu_pkg::state_e): IDLE, RMW_WR.
//  IDLE:
//   - req_ready_o=1.
//   - dmem_addr_o=req_addr_i[ADDR_W+1:2], driven combinationally.
//  Load accepted in IDLE:
//   - Lane is picked by addr[1:0], little-endian: byte k = bits[8k+7:8k]; half at addr[1]=1 = bits[31:16].
//   - Extended result is registered; rsp_valid_o=1 on the next cycle, for exactly 1 cycle.
//   - Back-to-back loads give 1 result per cycle.
//  SW accepted in IDLE:
//   - dmem_st_en_o=1 in the same cycle, dmem_st_data_o=req_wdata_i.
//   - No response; state stays IDLE.
//  SB/SH accepted in IDLE:
//   - dmem_st_en_o=0.
//   - Merge dmem_ld_data_i with the req_wdata_i low byte/half into the addressed lane.
//   - Register the merged word and the word address; next state RMW_WR.
//  RMW_WR:
//   - req_ready_o=0; dmem_addr_o=registered address; dmem_st_data_o=merged word; dmem_st_en_o=1.
//   - Next state IDLE unconditionally. A request held valid is accepted in the following IDLE cycle.
//  Hazard: load to the same word right after an SB/SH sees the new data, because RMW_WR commits first.
//  dmem_st_data_o=req_wdata_i in IDLE when no RMW is in progress (value ignored when st_en=0).
//  Address wrap: bits above ADDR_W+1 do not exist; the word address wraps modulo 2**ADDR_W.
//  Reset mid-RMW: the pending write is discarded (st_en drops asynchronously) and state goes to IDLE.
//  req_valid_i=0: no DMEM enable, no response.
// CONFIGURATION
//  `define LSU_MISALIGN_TRAP_EN
//  With the macro:
//   - Misaligned access: SZ_H with addr[0]=1, or SZ_W with addr[1:0]!=0.
//   - Accepted with no DMEM write and rsp_valid_o=0.
//   - err_o=1 on the next cycle for 1 cycle.
//  Without the macro:
//   - Low address bits below the access size are ignored (access aligned down); err_o tied 0.
// STRUCTURE
//  Shared package lsu_pkg:
//   - size_e, state_e.
//   - Functions lane_merge(old,wdata,size,off) and lane_extract(word,size,off,uns).
//  One sub-module lsu_load_align: combinational extract + extend, reused by the response path.
// TESTING
//  1. DMEM[1]=0x11223344; SB addr 0x005 data 0xAB -> cycle1 st_en=0; cycle2 st_en=1, data 0x1122AB44, ready=0.
//  2. Then LB 0x005 -> rsp 0xFFFFFFAB one cycle later; LBU 0x005 -> 0x000000AB; LH 0x006 -> 0x00001122.
//  3. SW 0x008 data 0xDEADBEEF -> st_en=1 same cycle, addr=2; LW 0x008 next cycle -> rsp 0xDEADBEEF.
//  4. SH 0x00E data 0x8001 over 0 -> written 0x80010000; LH 0x00E -> 0xFFFF8001.
//  5. Assert rst_i during RMW_WR -> st_en drops immediately; memory word unchanged; state IDLE.
//  6. With LSU_MISALIGN_TRAP_EN: LW 0x006 -> err_o=1 next cycle, rsp_valid_o=0; SW 0x003 -> no write.
//     Without the macro: LW 0x006 returns the word at 0x004.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit (little-endian, 32-bit words).
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  // Size code 3 falls into the default arm and behaves as a word.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] wdata,
    input logic [1:0]        size,
    input logic [1:0]        off
  );
    logic [DATA_W-1:0] r;
    r = old;
    case (size)
      SZ_B:    r[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] lane_extract(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic [1:0]        off,
    input logic              uns
  );
    logic [DATA_W-1:0] r;
    logic [7:0]        b;
    logic [15:0]       h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = {{24{~uns & b[7]}}, b};
      SZ_H:    r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Execute-stage request/response and DMEM bus of the LSU; slave = LSU view, master = core+DMEM view.
interface lsu_rmw_if #(
  parameter int ADDR_W = 10
);
  import lsu_pkg::*;

  logic                req_valid_i;
  logic                req_ready_o;
  logic                req_we_i;
  logic [1:0]          req_size_i;
  logic                req_unsigned_i;
  logic [ADDR_W+1:0]   req_addr_i;
  logic [DATA_W-1:0]   req_wdata_i;
  logic                rsp_valid_o;
  logic [DATA_W-1:0]   rsp_rdata_o;
  logic                err_o;
  logic [ADDR_W-1:0]   dmem_addr_o;
  logic [DATA_W-1:0]   dmem_st_data_o;
  logic                dmem_st_en_o;
  logic [DATA_W-1:0]   dmem_ld_data_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  dmem_ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, err_o,
    output dmem_addr_o, dmem_st_data_o, dmem_st_en_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output dmem_ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, err_o,
    input  dmem_addr_o, dmem_st_data_o, dmem_st_en_o
  );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half/word out of a DMEM word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        off_i,
  input  logic              uns_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = lane_extract(word_i, size_i, off_i, uns_i);

endmodule

// File: rtl/lsu_rmw.sv
// LSU: SB/SH become a two-cycle read-modify-write on word-only DMEM; loads are aligned and extended.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are dropped and flagged on err_o.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic    clk_i,
  input  logic    rst_i,
  lsu_rmw_if.slave bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, ld_word;
  logic                vld_q;

  logic                fire, mis, is_word;
  logic                ld_fire, sw_fire, rmw_fire;
  logic [1:0]          off;
  logic [ADDR_W-1:0]   req_waddr;

  logic                ready;
  logic [ADDR_W-1:0]   dmem_addr;
  logic [DATA_W-1:0]   st_data;
  logic                st_en;

  // Acceptance keys off state directly so ready never feeds back into itself.
  assign fire      = bus.req_valid_i & (state_q == IDLE);
  assign off       = bus.req_addr_i[1:0];
  assign is_word   = bus.req_size_i[1];
  assign req_waddr = bus.req_addr_i[ADDR_W+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ((bus.req_size_i == SZ_H) & off[0]) | (is_word & (off != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign ld_fire  = fire & ~bus.req_we_i & ~mis;
  assign sw_fire  = fire &  bus.req_we_i &  is_word & ~mis;
  assign rmw_fire = fire &  bus.req_we_i & ~is_word & ~mis;

  always_comb begin
    state_d   = state_q;
    merge_d   = merge_q;
    addr_d    = addr_q;
    ready     = 1'b0;
    dmem_addr = addr_q;
    st_data   = merge_q;
    st_en     = 1'b0;
    case (state_q)
      IDLE: begin
        ready     = 1'b1;
        dmem_addr = req_waddr;
        st_data   = bus.req_wdata_i;
        st_en     = sw_fire;
        if (rmw_fire) begin
          merge_d = lane_merge(bus.dmem_ld_data_i, bus.req_wdata_i, bus.req_size_i, off);
          addr_d  = req_waddr;
          state_d = RMW_WR;
        end
      end
      RMW_WR: begin
        st_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .word_i (bus.dmem_ld_data_i),
    .size_i (bus.req_size_i),
    .off_i  (off),
    .uns_i  (bus.req_unsigned_i),
    .data_o (ld_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      merge_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
      vld_q   <= ld_fire;
      if (ld_fire) rdata_q <= ld_word;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= fire & mis;
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.req_ready_o    = ready;
  assign bus.dmem_addr_o    = dmem_addr;
  assign bus.dmem_st_data_o = st_data;
  assign bus.dmem_st_en_o   = st_en;
  assign bus.rsp_valid_o    = vld_q;
  assign bus.rsp_rdata_o    = rdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural word-only DMEM.
module tb_lsu_rmw;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  int   checks = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  lsu_rmw_if #(.ADDR_W(10)) bus ();
  lsu_rmw #(.ADDR_W(10)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (bus.dmem_st_en_o) begin
      mem[bus.dmem_addr_o] <= bus.dmem_st_data_o;
    end
  end
  assign bus.dmem_ld_data_i = mem[bus.dmem_addr_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic we, input logic [1:0] sz, input logic u,
                     input logic [11:0] a, input logic [31:0] d);
    bus.req_valid_i    = v;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = u;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = d;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 2'd0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_err", {31'b0, bus.err_o}, 32'd0);
    chk("rst_st_en", {31'b0, bus.dmem_st_en_o}, 32'd0);
    chk("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
    rst = 1'b0;
    mem_clr = 1'b0;

    // preload DMEM[1] through a word store
    tick(); req(1'b1, 1'b1, 2'd2, 1'b0, 12'h004, 32'h11223344); #2;
    chk("sw_pre_st_en", {31'b0, bus.dmem_st_en_o}, 32'd1);
    chk("sw_pre_addr", {22'b0, bus.dmem_addr_o}, 32'd1);

    // SB 0x005 -> RMW
    tick(); req(1'b1, 1'b1, 2'd0, 1'b0, 12'h005, 32'h000000AB); #2;
    chk("sb_c1_st_en", {31'b0, bus.dmem_st_en_o}, 32'd0);
    chk("sb_c1_ready", {31'b0, bus.req_ready_o}, 32'd1);
    tick(); idle(); #2;
    chk("sb_c2_ready", {31'b0, bus.req_ready_o}, 32'd0);
    chk("sb_c2_st_en", {31'b0, bus.dmem_st_en_o}, 32'd1);
    chk("sb_c2_data", bus.dmem_st_data_o, 32'h1122AB44);
    chk("sb_c2_addr", {22'b0, bus.dmem_addr_o}, 32'd1);

    // loads back-to-back, first one right after the RMW commit
    tick(); req(1'b1, 1'b0, 2'd0, 1'b0, 12'h005, 32'h0); #2;
    chk("sb_mem", mem[1], 32'h1122AB44);
    tick(); req(1'b1, 1'b0, 2'd0, 1'b1, 12'h005, 32'h0); #2;
    chk("lb_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
    chk("lb_data", bus.rsp_rdata_o, 32'hFFFFFFAB);
    tick(); req(1'b1, 1'b0, 2'd1, 1'b0, 12'h006, 32'h0); #2;
    chk("lbu_data", bus.rsp_rdata_o, 32'h000000AB);
    tick(); idle(); #2;
    chk("lh_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
    chk("lh_data", bus.rsp_rdata_o, 32'h00001122);
    tick(); #2;
    chk("idle_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    chk("idle_st_en", {31'b0, bus.dmem_st_en_o}, 32'd0);

    // SW then LW (size code 3 behaves as word)
    tick(); req(1'b1, 1'b1, 2'd2, 1'b0, 12'h008, 32'hDEADBEEF); #2;
    chk("sw_st_en", {31'b0, bus.dmem_st_en_o}, 32'd1);
    chk("sw_addr", {22'b0, bus.dmem_addr_o}, 32'd2);
    chk("sw_data", bus.dmem_st_data_o, 32'hDEADBEEF);
    tick(); req(1'b1, 1'b0, 2'd3, 1'b0, 12'h008, 32'h0); #2;
    tick(); idle(); #2;
    chk("lw_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
    chk("lw_data", bus.rsp_rdata_o, 32'hDEADBEEF);

    // SH upper half over zero
    tick(); req(1'b1, 1'b1, 2'd1, 1'b0, 12'h00E, 32'h00008001); #2;
    chk("sh_c1_st_en", {31'b0, bus.dmem_st_en_o}, 32'd0);
    tick(); idle(); #2;
    chk("sh_c2_st_en", {31'b0, bus.dmem_st_en_o}, 32'd1);
    chk("sh_c2_addr", {22'b0, bus.dmem_addr_o}, 32'd3);
    chk("sh_c2_data", bus.dmem_st_data_o, 32'h80010000);
    tick(); req(1'b1, 1'b0, 2'd1, 1'b0, 12'h00E, 32'h0); #2;
    tick(); idle(); #2;
    chk("lh_neg_data", bus.rsp_rdata_o, 32'hFFFF8001);

    // top of the byte address space maps to the last word
    tick(); req(1'b1, 1'b0, 2'd2, 1'b0, 12'hFFC, 32'h0); #2;
    chk("wrap_addr", {22'b0, bus.dmem_addr_o}, 32'h3FF);

    // reset while the RMW write is pending
    tick(); req(1'b1, 1'b1, 2'd0, 1'b0, 12'h010, 32'h00000055); #2;
    tick(); idle(); #2;
    chk("rmw_rst_pre_st_en", {31'b0, bus.dmem_st_en_o}, 32'd1);
    rst = 1'b1; #1;
    chk("rmw_rst_st_en", {31'b0, bus.dmem_st_en_o}, 32'd0);
    chk("rmw_rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
    tick(); #2;
    chk("rmw_rst_mem", mem[4], 32'h0);
    rst = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
    tick(); req(1'b1, 1'b0, 2'd2, 1'b0, 12'h006, 32'h0); #2;
    chk("mis_lw_st_en", {31'b0, bus.dmem_st_en_o}, 32'd0);
    tick(); req(1'b1, 1'b1, 2'd2, 1'b0, 12'h003, 32'h12345678); #2;
    chk("mis_lw_err", {31'b0, bus.err_o}, 32'd1);
    chk("mis_lw_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    chk("mis_sw_st_en", {31'b0, bus.dmem_st_en_o}, 32'd0);
    tick(); idle(); #2;
    chk("mis_sw_err", {31'b0, bus.err_o}, 32'd1);
    chk("mis_sw_mem", mem[0], 32'h0);
    tick(); #2;
    chk("mis_err_clr", {31'b0, bus.err_o}, 32'd0);
`else
    tick(); req(1'b1, 1'b0, 2'd2, 1'b0, 12'h006, 32'h0); #2;
    tick(); req(1'b1, 1'b1, 2'd2, 1'b0, 12'h003, 32'h12345678); #2;
    chk("al_lw_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
    chk("al_lw_data", bus.rsp_rdata_o, 32'h1122AB44);
    chk("al_err", {31'b0, bus.err_o}, 32'd0);
    chk("al_sw_st_en", {31'b0, bus.dmem_st_en_o}, 32'd1);
    chk("al_sw_addr", {22'b0, bus.dmem_addr_o}, 32'd0);
    tick(); idle(); #2;
    chk("al_sw_mem", mem[0], 32'h12345678);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
